// File: rtl/pipe_controller.sv
// Pipelined main/ALU control decoder: decodes op/funct in D and carries control through E/M/W,
// with flush handling and a multicycle multiply sequencer that stalls the pipeline.
module pipe_controller #(
    parameter int MULT_LAT = 4,
    parameter bit EXT_ISA  = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] opD,
    input  logic [5:0] functD,
    input  logic       flushE,
    output logic       branchD,
    output logic       bneD,
    output logic       jumpD,
    output logic       illegalD,
    output logic       regwriteE,
    output logic       memtoregE,
    output logic       memwriteE,
    output logic       alusrcE,
    output logic       regdstE,
    output logic       linkE,
    output logic       multE,
    output logic [2:0] alucontrolE,
    output logic       regwriteM,
    output logic       memtoregM,
    output logic       memwriteM,
    output logic       linkM,
    output logic       regwriteW,
    output logic       memtoregW,
    output logic       linkW,
    output logic       stall_mult
);

    typedef struct packed {
        logic       regwrite;
        logic       memtoreg;
        logic       memwrite;
        logic       alusrc;
        logic       regdst;
        logic       link;
        logic       mult;
        logic [2:0] aluctrl;
    } ctrlE_t;

    typedef struct packed {
        logic regwrite;
        logic memtoreg;
        logic memwrite;
        logic link;
    } ctrlM_t;

    typedef struct packed {
        logic regwrite;
        logic memtoreg;
        logic link;
    } ctrlW_t;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    localparam logic [3:0] LAST_CNT = 4'(MULT_LAT - 1);

    ctrlE_t     w_ctrlD;
    logic       w_branchD;
    logic       w_bneD;
    logic       w_jumpD;
    logic       w_illegalD;
    ctrlE_t     r_ctrlE;
    ctrlM_t     r_ctrlM;
    ctrlW_t     r_ctrlW;
    state_t     r_state;
    state_t     w_stateNext;
    logic [3:0] r_cnt;
    logic [3:0] w_cntNext;
    logic       w_stall;

    // Illegal encodings leave every control at zero so they flow down the pipe as bubbles.
    always_comb begin
        w_ctrlD    = '0;
        w_branchD  = 1'b0;
        w_bneD     = 1'b0;
        w_jumpD    = 1'b0;
        w_illegalD = 1'b0;
        case (opD)
            6'b000000: begin
                w_ctrlD.regwrite = 1'b1;
                w_ctrlD.regdst   = 1'b1;
                case (functD)
                    6'b100000: w_ctrlD.aluctrl = 3'b010;
                    6'b100010: w_ctrlD.aluctrl = 3'b110;
                    6'b100100: w_ctrlD.aluctrl = 3'b000;
                    6'b100101: w_ctrlD.aluctrl = 3'b001;
                    6'b101010: w_ctrlD.aluctrl = 3'b111;
                    6'b011000: begin
                        w_ctrlD.mult    = 1'b1;
                        w_ctrlD.aluctrl = 3'b010;
                    end
                    default: begin
                        w_ctrlD    = '0;
                        w_illegalD = 1'b1;
                    end
                endcase
            end
            6'b100011: begin
                w_ctrlD.regwrite = 1'b1;
                w_ctrlD.alusrc   = 1'b1;
                w_ctrlD.memtoreg = 1'b1;
                w_ctrlD.aluctrl  = 3'b010;
            end
            6'b101011: begin
                w_ctrlD.memwrite = 1'b1;
                w_ctrlD.alusrc   = 1'b1;
                w_ctrlD.aluctrl  = 3'b010;
            end
            6'b000100: begin
                w_branchD       = 1'b1;
                w_ctrlD.aluctrl = 3'b110;
            end
            6'b001000: begin
                w_ctrlD.regwrite = 1'b1;
                w_ctrlD.alusrc   = 1'b1;
                w_ctrlD.aluctrl  = 3'b010;
            end
            6'b000010: w_jumpD = 1'b1;
            6'b000101: begin
                if (EXT_ISA) begin
                    w_branchD       = 1'b1;
                    w_bneD          = 1'b1;
                    w_ctrlD.aluctrl = 3'b110;
                end else begin
                    w_illegalD = 1'b1;
                end
            end
            6'b001100, 6'b001101, 6'b001010: begin
                if (EXT_ISA) begin
                    w_ctrlD.regwrite = 1'b1;
                    w_ctrlD.alusrc   = 1'b1;
                    w_ctrlD.aluctrl  = (opD == 6'b001100) ? 3'b000 :
                                       (opD == 6'b001101) ? 3'b001 : 3'b111;
                end else begin
                    w_illegalD = 1'b1;
                end
            end
            6'b000011: begin
                if (EXT_ISA) begin
                    w_jumpD          = 1'b1;
                    w_ctrlD.regwrite = 1'b1;
                    w_ctrlD.link     = 1'b1;
                end else begin
                    w_illegalD = 1'b1;
                end
            end
            default: w_illegalD = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
        end
    end

    // A flush in any state abandons the multiply, since the mult is squashed out of E.
    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        if (flushE) begin
            w_stateNext = IDLE;
            w_cntNext   = 4'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (r_ctrlE.mult && (MULT_LAT > 1)) begin
                        w_stateNext = BUSY;
                        w_cntNext   = 4'd1;
                    end
                end
                BUSY: begin
                    if (r_cnt == LAST_CNT) begin
                        w_stateNext = IDLE;
                        w_cntNext   = 4'd0;
                    end else begin
                        w_cntNext = r_cnt + 4'd1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        w_stall = 1'b0;
        case (r_state)
            IDLE: w_stall = r_ctrlE.mult && (MULT_LAT > 1);
            BUSY: w_stall = (r_cnt != LAST_CNT);
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ctrlE <= '0;
        end else if (flushE) begin
            r_ctrlE <= '0;
        end else if (!w_stall) begin
            r_ctrlE <= w_ctrlD;
        end
    end

    // While the mult holds E, M receives bubbles so nothing downstream is duplicated.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ctrlM <= '0;
            r_ctrlW <= '0;
        end else begin
            r_ctrlM <= w_stall ? '0 : {r_ctrlE.regwrite, r_ctrlE.memtoreg, r_ctrlE.memwrite, r_ctrlE.link};
            r_ctrlW <= {r_ctrlM.regwrite, r_ctrlM.memtoreg, r_ctrlM.link};
        end
    end

    assign branchD     = w_branchD;
    assign bneD        = w_bneD;
    assign jumpD       = w_jumpD;
    assign illegalD    = w_illegalD;
    assign regwriteE   = r_ctrlE.regwrite;
    assign memtoregE   = r_ctrlE.memtoreg;
    assign memwriteE   = r_ctrlE.memwrite;
    assign alusrcE     = r_ctrlE.alusrc;
    assign regdstE     = r_ctrlE.regdst;
    assign linkE       = r_ctrlE.link;
    assign multE       = r_ctrlE.mult;
    assign alucontrolE = r_ctrlE.aluctrl;
    assign regwriteM   = r_ctrlM.regwrite;
    assign memtoregM   = r_ctrlM.memtoreg;
    assign memwriteM   = r_ctrlM.memwrite;
    assign linkM       = r_ctrlM.link;
    assign regwriteW   = r_ctrlW.regwrite;
    assign memtoregW   = r_ctrlW.memtoreg;
    assign linkW       = r_ctrlW.link;
    assign stall_mult  = w_stall;

endmodule
